// File: rtl/fechadura_pkg.sv
// ---------------------------------------------------------------------------
// fechadura_pkg
// Shared definitions for the parametrised code lock:
//   - state_t   : lock controller states (PROG only reachable when the
//                 FECHADURA_PROG_EN macro is defined)
//   - SEG_BLANK : all segments off
//   - SEG_HEX   : active-high {A,B,C,D,E,F,G} patterns for hex digits 0..F
//   - hex_to_seg: table lookup helper used by the display decoder
// ---------------------------------------------------------------------------
package fechadura_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ENTRADA  = 3'd1,
      ABERTO   = 3'd2,
      ERRO     = 3'd3,
      BLOQUEIO = 3'd4,
      PROG     = 3'd5
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b000_0000;

   // Index is the hex value, bit 6 is segment A, bit 0 is segment G.
   localparam logic [6:0] SEG_HEX [16] = '{
      7'b111_1110,  // 0
      7'b011_0000,  // 1
      7'b110_1101,  // 2
      7'b111_1001,  // 3
      7'b011_0011,  // 4
      7'b101_1011,  // 5
      7'b101_1111,  // 6
      7'b111_0000,  // 7
      7'b111_1111,  // 8
      7'b111_1011,  // 9
      7'b111_0111,  // A
      7'b001_1111,  // b
      7'b100_1110,  // C
      7'b011_1101,  // d
      7'b100_1111,  // E
      7'b100_0111   // F
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
      return SEG_HEX[d];
   endfunction

endpackage

// File: rtl/fechadura_param_decod_7seg.sv
// ---------------------------------------------------------------------------
// decod_7seg
// Combinational hex-to-7-segment decoder for the lock display.
// Ports:
//   i_digit [3:0]  digit to show (0..F)
//   i_blank        1 = all segments off regardless of i_digit
//   o_seg   [6:0]  active-high segments {A,B,C,D,E,F,G}
// ---------------------------------------------------------------------------
module decod_7seg
   import fechadura_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank) begin
         o_seg = hex_to_seg(i_digit);
      end
   end

endmodule

// File: rtl/fechadura_param.sv
// ---------------------------------------------------------------------------
// fechadura_param
// Parametrised digit-sequence code lock. Digits are accepted on the rising
// edge of `insere`, the last accepted digit is shown on a 7-segment display,
// a correct CODE_LEN-digit code opens the lock (LED) for OPEN_CYCLES cycles,
// a wrong code pulses `erro`, and MAX_TRIES consecutive wrong codes lock the
// keypad out (`bloqueado`) for LOCK_CYCLES cycles.
//
// Optional feature (macro FECHADURA_PROG_EN): adds input `programa`; while
// open, programa=1 enters PROG and the next CODE_LEN digits become the new
// code (MS digit first). Without the macro the code is the constant CODE.
//
// Ports:
//   clk        clock, all logic on posedge
//   reset      synchronous active-low reset
//   insere     digit strobe (rising edge accepts a digit)
//   numero     digit value, DIGIT_W bits
//   limpa      abort current entry (ignored while open / locked out)
//   programa   (FECHADURA_PROG_EN only) enter code programming while open
//   LED        1 while open
//   A..G       active-high segments of the last accepted digit
//   erro       one-cycle pulse on a wrong complete code
//   bloqueado  1 during lockout
// ---------------------------------------------------------------------------
module fechadura_param
   import fechadura_pkg::*;
#(
   parameter int                           DIGIT_W     = 4,
   parameter int                           CODE_LEN    = 4,
   parameter logic [CODE_LEN*DIGIT_W-1:0]  CODE        = 16'h5909,
   parameter int                           MAX_TRIES   = 3,
   parameter int                           OPEN_CYCLES = 8,
   parameter int                           LOCK_CYCLES = 16
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               insere,
   input  logic [DIGIT_W-1:0] numero,
   input  logic               limpa,
`ifdef FECHADURA_PROG_EN
   input  logic               programa,
`endif
   output logic               LED,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               D,
   output logic               E,
   output logic               F,
   output logic               G,
   output logic               erro,
   output logic               bloqueado
);

   localparam int CODE_W  = CODE_LEN * DIGIT_W;
   // Index only ever holds 0..CODE_LEN-1: the last digit is evaluated
   // in its acceptance cycle instead of being stored.
   localparam int IDX_W   = (CODE_LEN < 2) ? 1 : $clog2(CODE_LEN);
   localparam int FAIL_W  = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);
   localparam int TMR_MAX = ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES) - 1;
   localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic                r_mism;
   logic [FAIL_W-1:0]   r_fail;
   logic [TMR_W-1:0]    r_timer;
   logic                r_insere_d;
   logic [DIGIT_W-1:0]  r_digit;
   logic                r_blank;
   logic                r_led;
   logic                r_erro;
   logic                r_bloq;

   logic [CODE_W-1:0]   w_code;
   logic [DIGIT_W-1:0]  w_slice [CODE_LEN];
   logic                w_ac;
   logic                w_mism_acc;
   logic                w_last;
   logic                w_fail_last;
   logic [6:0]          w_seg;

`ifdef FECHADURA_PROG_EN
   logic [CODE_W-1:0]   r_code;
   assign w_code = r_code;
`else
   assign w_code = CODE;
`endif

   // Slice 0 is the first digit entered, taken from the MS end of the code.
   generate
      for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_slice
         assign w_slice[gi] = w_code[(CODE_LEN-1-gi)*DIGIT_W +: DIGIT_W];
      end
   endgenerate

   assign w_ac        = insere & ~r_insere_d;
   // r_idx and r_mism are both 0 whenever the machine sits in IDLE, so the
   // same accumulate expression covers the first digit as well.
   assign w_mism_acc  = r_mism | (numero != w_slice[r_idx]);
   assign w_last      = (int'(r_idx) == CODE_LEN - 1);
   assign w_fail_last = (int'(r_fail) + 1 == MAX_TRIES);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_mism     <= 1'b0;
         r_fail     <= '0;
         r_timer    <= '0;
         r_insere_d <= 1'b0;
         r_digit    <= '0;
         r_blank    <= 1'b1;
         r_led      <= 1'b0;
         r_erro     <= 1'b0;
         r_bloq     <= 1'b0;
`ifdef FECHADURA_PROG_EN
         r_code     <= CODE;
`endif
      end else begin
         r_insere_d <= insere;
         case (r_state)
            IDLE, ENTRADA: begin
               // limpa takes priority; a digit strobed in the same cycle is lost
               if (limpa) begin
                  r_state <= IDLE;
                  r_idx   <= '0;
                  r_mism  <= 1'b0;
                  r_blank <= 1'b1;
               end else if (w_ac) begin
                  r_digit <= numero;
                  r_blank <= 1'b0;
                  if (w_last) begin
                     r_idx  <= '0;
                     r_mism <= 1'b0;
                     if (!w_mism_acc) begin
                        r_state <= ABERTO;
                        r_fail  <= '0;
                        r_timer <= TMR_W'(OPEN_CYCLES - 1);
                        r_led   <= 1'b1;
                     end else if (w_fail_last) begin
                        r_state <= BLOQUEIO;
                        r_fail  <= '0;
                        r_timer <= TMR_W'(LOCK_CYCLES - 1);
                        r_bloq  <= 1'b1;
                     end else begin
                        r_state <= ERRO;
                        r_fail  <= r_fail + 1'b1;
                        r_erro  <= 1'b1;
                     end
                  end else begin
                     r_state <= ENTRADA;
                     r_idx   <= r_idx + 1'b1;
                     r_mism  <= w_mism_acc;
                  end
               end
            end

            ABERTO: begin
`ifdef FECHADURA_PROG_EN
               // Programming freezes the open timer; LED stays on until done.
               if (programa) begin
                  r_state <= PROG;
               end else
`endif
               if (r_timer == '0) begin
                  r_state <= IDLE;
                  r_led   <= 1'b0;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end

            ERRO: begin
               r_state <= IDLE;
               r_erro  <= 1'b0;
            end

            BLOQUEIO: begin
               if (r_timer == '0) begin
                  r_state <= IDLE;
                  r_bloq  <= 1'b0;
                  r_blank <= 1'b1;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end

`ifdef FECHADURA_PROG_EN
            PROG: begin
               if (w_ac) begin
                  r_code[(CODE_LEN-1-int'(r_idx))*DIGIT_W +: DIGIT_W] <= numero;
                  r_digit <= numero;
                  r_blank <= 1'b0;
                  if (w_last) begin
                     r_state <= IDLE;
                     r_idx   <= '0;
                     r_led   <= 1'b0;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                  end
               end
            end
`endif

            default: begin
               r_state <= IDLE;
               r_idx   <= '0;
               r_mism  <= 1'b0;
               r_led   <= 1'b0;
               r_erro  <= 1'b0;
               r_bloq  <= 1'b0;
            end
         endcase
      end
   end

   decod_7seg u_decod (
      .i_digit (4'(r_digit)),
      .i_blank (r_blank),
      .o_seg   (w_seg)
   );

   assign {A, B, C, D, E, F, G} = w_seg;
   assign LED       = r_led;
   assign erro      = r_erro;
   assign bloqueado = r_bloq;

endmodule

// File: tb/tb_fechadura_param.sv
// ---------------------------------------------------------------------------
// tb_fechadura_param
// Scoreboard bench for fechadura_param. Stimulus tasks feed a transaction-
// level model of the lock (digit lists, a fail count and "busy until" cycle
// numbers); the model pushes expected output pulses (kind, start cycle,
// width) into a queue that an independent monitor pops whenever LED, erro
// or bloqueado completes a pulse. Display contents are checked after every
// accepted or ignored digit and every limpa.
// ---------------------------------------------------------------------------
module tb_fechadura_param;

   localparam int          DW   = 4;
   localparam int          CL   = 4;
   localparam logic [15:0] CODE = 16'h5909;
   localparam int          MT   = 3;
   localparam int          OC   = 8;
   localparam int          LC   = 16;

   logic          clk    = 1'b0;
   logic          reset  = 1'b0;
   logic          insere = 1'b0;
   logic [DW-1:0] numero = '0;
   logic          limpa  = 1'b0;
`ifdef FECHADURA_PROG_EN
   logic          programa = 1'b0;
`endif
   logic LED, A, B, C, D, E, F, G, erro, bloqueado;

   fechadura_param #(
      .DIGIT_W(DW), .CODE_LEN(CL), .CODE(CODE),
      .MAX_TRIES(MT), .OPEN_CYCLES(OC), .LOCK_CYCLES(LC)
   ) dut (
      .clk(clk), .reset(reset), .insere(insere), .numero(numero), .limpa(limpa),
`ifdef FECHADURA_PROG_EN
      .programa(programa),
`endif
      .LED(LED), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
      .erro(erro), .bloqueado(bloqueado)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // kind: 0 = LED, 1 = erro, 2 = bloqueado
   typedef struct {
      int kind;
      int start;
      int width;
   } ev_t;
   ev_t sb[$];

   // ---------------- reference model ----------------
   int  m_code[CL];
   int  m_entry[$];
   int  m_fail;
   int  m_busy_until;   // first cycle whose acceptance is honoured again
   int  m_blank_at;     // cycle at which lockout end blanks the display
   bit  m_pend_blank;
   int  m_disp;         // -1 = blank
   bit  m_prog;
   int  m_prog_idx;
   bit  mon_en = 1'b0;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1111110;   1: return 7'b0110000;
         2: return 7'b1101101;   3: return 7'b1111001;
         4: return 7'b0110011;   5: return 7'b1011011;
         6: return 7'b1011111;   7: return 7'b1110000;
         8: return 7'b1111111;   9: return 7'b1111011;
         10: return 7'b1110111;  11: return 7'b0011111;
         12: return 7'b1001110;  13: return 7'b0111101;
         14: return 7'b1001111;  default: return 7'b1000111;
      endcase
   endfunction

   task automatic model_reset();
      m_fail = 0;
      m_busy_until = 0;
      m_pend_blank = 1'b0;
      m_blank_at = 0;
      m_entry.delete();
      m_disp = -1;
      m_prog = 1'b0;
      m_prog_idx = 0;
      for (int i = 0; i < CL; i++) m_code[i] = int'((CODE >> ((CL-1-i)*DW)) & 16'hF);
   endtask

   task automatic push_ev(input int kind, input int start, input int width);
      ev_t e;
      e.kind = kind; e.start = start; e.width = width;
      sb.push_back(e);
   endtask

   task automatic model_digit(input int d, input int acc);
      bit ok;
      if (m_pend_blank && acc >= m_blank_at) begin
         m_disp = -1;
         m_pend_blank = 1'b0;
      end
      if (m_prog) begin
         m_code[m_prog_idx] = d;
         m_disp = d;
         m_prog_idx++;
         if (m_prog_idx == CL) begin
            m_prog = 1'b0;
            sb[$].width = acc - sb[$].start;
            m_busy_until = acc + 1;
         end
         return;
      end
      if (acc < m_busy_until) return;
      m_disp = d;
      m_entry.push_back(d);
      if (m_entry.size() == CL) begin
         ok = 1'b1;
         for (int i = 0; i < CL; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
         m_entry.delete();
         if (ok) begin
            push_ev(0, acc, OC);
            m_fail = 0;
            m_busy_until = acc + OC + 1;
         end else if (m_fail + 1 == MT) begin
            push_ev(2, acc, LC);
            m_fail = 0;
            m_busy_until = acc + LC + 1;
            m_pend_blank = 1'b1;
            m_blank_at = acc + LC;
         end else begin
            push_ev(1, acc, 1);
            m_fail++;
            m_busy_until = acc + 2;
         end
      end
   endtask

   task automatic model_limpa(input int lc);
      if (m_pend_blank && lc >= m_blank_at) begin
         m_disp = -1;
         m_pend_blank = 1'b0;
      end
      if (m_prog || lc < m_busy_until) return;
      m_entry.delete();
      m_disp = -1;
   endtask

   // ---------------- checks ----------------
   task automatic check_disp(input string nm);
      logic [6:0] exp_seg;
      logic [6:0] act_seg;
      exp_seg = (m_disp < 0) ? 7'b0000000 : seg_of(m_disp);
      act_seg = {A, B, C, D, E, F, G};
      tests++;
      if (act_seg !== exp_seg) begin
         fails++;
         $display("FAIL %s @cyc %0d: segments got %b, expected %b", nm, cyc, act_seg, exp_seg);
      end else begin
         $display("[TB] %s @cyc %0d: segments %b ok", nm, cyc, act_seg);
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      logic [9:0] act;
      act = {LED, erro, bloqueado, A, B, C, D, E, F, G};
      tests++;
      if (act !== 10'b0) begin
         fails++;
         $display("FAIL %s: {LED,erro,bloqueado,A..G} got %b, expected 0000000000", nm, act);
      end else begin
         $display("[TB] %s: all outputs low ok", nm);
      end
   endtask

   task automatic check_event(input int k, input int s, input int w);
      ev_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL event: unexpected pulse kind=%0d start=%0d width=%0d, expected none", k, s, w);
         return;
      end
      e = sb.pop_front();
      if (e.kind != k || e.start != s || e.width != w) begin
         fails++;
         $display("FAIL event: got kind=%0d start=%0d width=%0d, expected kind=%0d start=%0d width=%0d",
                  k, s, w, e.kind, e.start, e.width);
      end else begin
         $display("[TB] event kind=%0d start=%0d width=%0d ok", k, s, w);
      end
   endtask

   // Monitor: measures every LED/erro/bloqueado pulse, compares on its fall.
   initial begin
      logic [2:0] cur;
      logic [2:0] prev;
      int         st[3];
      int         cnt[3];
      prev = 3'b000;
      for (int k = 0; k < 3; k++) begin st[k] = 0; cnt[k] = 0; end
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur = {bloqueado, erro, LED};
            for (int k = 0; k < 3; k++) begin
               if (cur[k] && !prev[k]) begin st[k] = cyc; cnt[k] = 0; end
               if (cur[k]) cnt[k]++;
               if (!cur[k] && prev[k]) check_event(k, st[k], cnt[k]);
            end
            prev = cur;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_digit(input int d, input int hold, input int gap);
      int acc;
      @(negedge clk);
      numero = 4'(d);
      insere = 1'b1;
      acc = cyc + 1;
      model_digit(d, acc);
      @(negedge clk);
      check_disp("digit");
      repeat (hold - 1) @(negedge clk);
      insere = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_code(input logic [15:0] c);
      logic [3:0] d;
      for (int i = 0; i < CL; i++) begin
         d = c[15-4*i -: 4];
         send_digit(int'(d), 1, 1);
      end
   endtask

   task automatic do_limpa(input bit with_digit, input int d);
      @(negedge clk);
      limpa = 1'b1;
      if (with_digit) begin
         insere = 1'b1;
         numero = 4'(d);
      end
      model_limpa(cyc + 1);
      @(negedge clk);
      limpa  = 1'b0;
      insere = 1'b0;
      check_disp("limpa");
   endtask

   task automatic wait_ready();
      while (cyc + 1 < m_busy_until) @(negedge clk);
      if (m_pend_blank) begin
         m_disp = -1;
         m_pend_blank = 1'b0;
         check_disp("blank_after_lock");
      end
   endtask

   task automatic do_reset(input bit hold_insere, input int d);
      int acc;
      @(negedge clk);
      reset  = 1'b0;
      insere = hold_insere;
      numero = 4'(d);
      repeat (2) @(negedge clk);
      model_reset();
      check_reset_outputs("reset_mid");
      reset = 1'b1;
      if (hold_insere) begin
         acc = cyc + 1;
         model_digit(d, acc);
      end
      @(negedge clk);
      check_disp("held_through_reset");
      insere = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rc;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_hold");
      reset = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      check_reset_outputs("after_release");

      // correct code, then one wrong code
      send_code(16'h5909);
      wait_ready();
      send_code(16'h5919);
      wait_ready();

      // two more wrong codes -> lockout; correct code and limpa ignored during it
      send_code(16'h1111);
      wait_ready();
      send_code(16'h2222);
      send_code(16'h5909);
      do_limpa(1'b0, 0);
      wait_ready();
      send_code(16'h5909);
      wait_ready();

      // partial entry aborted by limpa
      send_digit(5, 1, 1);
      send_digit(9, 1, 1);
      do_limpa(1'b0, 0);
      send_code(16'h5909);
      wait_ready();

      // held strobe yields one digit; limpa beats a simultaneous digit
      send_digit(5, 5, 1);
      send_digit(9, 1, 1);
      send_digit(0, 1, 1);
      send_digit(9, 1, 1);
      wait_ready();
      send_digit(5, 1, 1);
      send_digit(9, 1, 1);
      do_limpa(1'b1, 0);
      send_code(16'h5909);
      wait_ready();

      // reset mid-operation clears the fail count; strobe held through reset counts
      send_code(16'h0000);
      wait_ready();
      send_code(16'h0001);
      wait_ready();
      do_reset(1'b1, 5);
      send_digit(9, 1, 1);
      send_digit(9, 1, 1);
      send_digit(9, 1, 1);
      wait_ready();

      // randomized attempts
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 9) < 4)
            rc = {4'(m_code[0]), 4'(m_code[1]), 4'(m_code[2]), 4'(m_code[3])};
         else
            rc = 16'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++)
               send_digit(int'(rc[15-4*i -: 4]), 1, 1);
            do_limpa(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         end
         for (int i = 0; i < CL; i++)
            send_digit(int'(rc[15-4*i -: 4]), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
         wait_ready();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

`ifdef FECHADURA_PROG_EN
      send_code({4'(m_code[0]), 4'(m_code[1]), 4'(m_code[2]), 4'(m_code[3])});
      @(negedge clk);
      programa = 1'b1;
      m_prog = 1'b1;
      m_prog_idx = 0;
      @(negedge clk);
      programa = 1'b0;
      send_code(16'h1234);
      wait_ready();
      send_code(16'h5909);
      wait_ready();
      send_code(16'h1234);
      wait_ready();
`endif

      repeat (5) @(negedge clk);
      tests++;
      if (sb.size() != 0 || LED !== 1'b0 || erro !== 1'b0 || bloqueado !== 1'b0) begin
         fails++;
         $display("FAIL drain: %0d expected pulses pending, LED=%b erro=%b bloqueado=%b, expected 0 pending and all low",
                  sb.size(), LED, erro, bloqueado);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fechadura_param.md
Name: fechadura_param

Overview:
- Parametrised digit-sequence code lock, successor to the single-code entry machine.
- Accepts digits strobed by `insere` and shows the last accepted digit on a 7-segment display.
- Compares the entered sequence against a CODE_LEN-digit code and drives `LED` while open.
- Counts failed attempts and enters a timed lockout after MAX_TRIES consecutive failures.
- Sits between the keypad/switch inputs and the board display/LED.

Parameters:
- DIGIT_W, 4: bits per digit; legal range 1..4, so digits fit the hex decoder.
- CODE_LEN, 4: digits per code; must be >= 1.
- CODE, 16'h5909: reset-default code, CODE_LEN*DIGIT_W bits. The first digit entered is compared with the MS slice.
- MAX_TRIES, 3: consecutive failures that trigger lockout; must be >= 1.
- OPEN_CYCLES, 8: cycles `LED` stays high after a correct code.
- LOCK_CYCLES, 16: lockout duration in cycles.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- insere  in  1  digit strobe; a digit is accepted on its rising edge, detected internally.
- numero  in  DIGIT_W  digit value, sampled in the acceptance cycle.
- limpa  in  1  abort the current entry; ignored in ABERTO and BLOQUEIO.
- LED  out  1  1 while the lock is open.
- A,B,C,D,E,F,G  out  1 each  active-high segments of the last accepted digit, hex 0..F.
- erro  out  1  one-cycle pulse on a wrong complete code.
- bloqueado  out  1  1 during lockout.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; digit index, mismatch flag, fail counter and timer all 0.
  - LED=0, erro=0, bloqueado=0, segments all 0 (blank).
  - insere_d=0, so an `insere` held high through reset release counts as a rising edge in the first active cycle.
- Acceptance event `ac` = insere & ~insere_d. Each held pulse yields exactly one digit.
- States: IDLE, ENTRADA, ABERTO, ERRO, BLOQUEIO.
- IDLE:
  - On `ac`: register the digit to the display.
  - Mismatch flag = (numero != code slice 0); index=1.
  - Go to ENTRADA, unless CODE_LEN==1, in which case evaluate immediately (see below).
- ENTRADA:
  - On `ac`: update the display; OR the mismatch flag with the compare against slice[index]; index++.
  - When the accepted digit is number CODE_LEN, evaluate in the same cycle:
    - No mismatch: go to ABERTO, fail counter=0, timer=OPEN_CYCLES-1.
    - Mismatch and fail+1==MAX_TRIES: go to BLOQUEIO, timer=LOCK_CYCLES-1, fail=0.
    - Otherwise: fail++ and go to ERRO.
  - `limpa`=1 without `ac`: go to IDLE, index=0, mismatch=0, display blank; the fail counter is kept.
  - `limpa` and `ac` in the same cycle: `limpa` wins and the digit is discarded.
- ABERTO:
  - LED=1. Timer decrements each cycle; at 0, go to IDLE and LED=0 on the next cycle.
  - `ac` is ignored, with no display update.
- ERRO:
  - erro=1 for exactly one cycle, then IDLE.
  - `ac` in that cycle is ignored.
- BLOQUEIO:
  - bloqueado=1; all `ac` and `limpa` are ignored.
  - Timer counts down; at 0, go to IDLE and blank the display.
- Latency:
  - Segments update on the clock after the acceptance cycle.
  - LED/erro/bloqueado assert one clock after the final digit's acceptance cycle.
- Reset mid-operation (any state) returns everything to the reset values, including the fail counter.
- Timer and index widths use $clog2 with a minimum of 1 bit. Counters never wrap past their terminal values.

Optional Feature:
- Macro FECHADURA_PROG_EN.
- When defined:
  - Adds input `programa` (1 bit).
  - `programa`=1 while in ABERTO enters state PROG; the OPEN timer is frozen.
  - The next CODE_LEN accepted digits overwrite the code register, MS slice first.
  - Then go to IDLE with LED=0.
  - The code register resets to CODE.
- When undefined: the code is the constant CODE, with no PROG state and no `programa` port.

Decomposition:
- Package `fechadura_pkg`:
  - State enum (IDLE, ENTRADA, ABERTO, ERRO, BLOQUEIO, PROG).
  - 7-bit segment patterns for 0..F plus SEG_BLANK.
- Sub-module `decod_7seg`:
  - Combinational hex-to-segment decoder driven by the registered digit plus a blank flag.
  - Outputs {A..G}.

Test Plan:
1. Reset low for 2 cycles, then high:
   - LED=0, erro=0, bloqueado=0, segments 0000000.
   - Enter 5,9,0,9 on separate `insere` pulses → LED=1 exactly 8 cycles; display shows 9 (A..G=1111011).
2. Enter 5,9,1,9 → one-cycle erro pulse one clock after the 4th digit's acceptance cycle; LED stays 0; fail=1.
3. Three wrong codes in a row:
   - Third → bloqueado=1 for 16 cycles; a correct code during lockout is ignored (LED=0).
   - After lockout, 5,9,0,9 opens.
4. Enter 5,9, then limpa=1 → display blank, state IDLE; 5,9,0,9 then opens (prior partial discarded).
5. Hold insere=1 across 5 cycles with numero=5 → exactly one digit accepted (index=1); limpa and insere rising in the same cycle → digit discarded.
6. With FECHADURA_PROG_EN: open with 5909, assert programa, enter 1,2,3,4 → 5909 now fails (erro) and 1234 opens.
